lsu_clken_gen: RTL

//  Parametrised LSU clock-enable generator for an NSTG-deep load/store pipe.

---
 rtl/lsu_clken_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lsu_clken_gen.sv
// LSU clock-enable generator: per-stage c1/c2/store/freeze enables, a hold-off
// FSM for the free-running LSU domain and a saturating idle-cycle counter.
module lsu_clken_gen #(
    parameter int NSTG   = 5,
    parameter int NFRZ   = 4,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              clk_override,
    input  logic              freeze,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [NSTG-1:0]   stg_valid,
    input  logic [NSTG-1:0]   stg_store,
    input  logic              buf_busy,
    input  logic [HOLD_W-1:0] hold_cfg,
    input  logic              idle_cnt_clr,
    output logic [NSTG-1:0]   c1_clken,
    output logic [NSTG-1:0]   c2_clken,
    output logic [NSTG-1:0]   store_c1_clken,
    output logic [NFRZ-1:0]   frz_c1_clken,
    output logic [NFRZ-1:0]   frz_c2_clken,
    output logic              free_c2_clken,
    output logic              lsu_idle,
    output logic [CNT_W-1:0]  idle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [NSTG-1:0]   c1_q, c1_d;
    logic [NFRZ-1:0]   frz_q, frz_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

    logic              act;
    logic [NSTG-1:0]   c1_prev;
    logic [NSTG-1:0]   store_raw;
    logic [NSTG-1:0]   frz_mask;
    logic [NFRZ-1:0]   frz_req;

    // Stage enables; stage 0 takes the DMA request as its upstream token.
    always_comb begin
        c1_prev   = {c1_q[NSTG-2:0], dma_req};
        c1_clken  = stg_valid | c1_prev | {NSTG{clk_override}};
        c2_clken  = c1_clken | c1_q | {NSTG{clk_override}};
        store_raw = (c1_clken & stg_store) | {NSTG{clk_override}};
        store_raw[0] = store_raw[0] | dma_write;
        frz_mask = '0;
        for (int i = 0; i < NFRZ; i++) begin
            frz_mask[i] = freeze;
        end
        store_c1_clken = store_raw & ~frz_mask;

        frz_req    = stg_valid[NFRZ-1:0];
        frz_req[0] = frz_req[0] | dma_req;
        frz_c1_clken = (frz_req | {NFRZ{clk_override}}) & {NFRZ{~freeze}};
        frz_c2_clken = (frz_c1_clken | frz_q | {NFRZ{clk_override}}) & {NFRZ{~freeze}};
    end

    // Hold-off FSM: keeps the free domain clocked hold_cfg cycles past the last activity.
    always_comb begin
        act     = (|stg_valid) | dma_req | buf_busy | clk_override;
        state_d = state_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (!act) begin
                    if (hold_cfg == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                        hcnt_d  = hold_cfg - HOLD_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (act) begin
                    state_d = ST_ACTIVE;
                end else if (hcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q - HOLD_W'(1);
                end
            end
            ST_IDLE: begin
                if (act) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        free_c2_clken = act | (state_q != ST_IDLE);
        lsu_idle      = (state_q == ST_IDLE);
    end

    // Token and counter next-state; c1 tokens only advance while the free domain runs.
    always_comb begin
        c1_d = free_c2_clken ? c1_clken : c1_q;
        for (int i = 0; i < NFRZ; i++) begin
            frz_d[i] = frz_c2_clken[i] ? frz_c1_clken[i] : frz_q[i];
        end
        idle_cnt_d = idle_cnt_q;
        if (idle_cnt_clr) begin
            idle_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && (idle_cnt_q != '1)) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
        idle_cnt = idle_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            c1_q       <= '0;
            frz_q      <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            c1_q       <= c1_d;
            frz_q      <= frz_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule
